// File: rtl/bp_be_instr_encoder_if.sv
// Command and instruction-word stream bundle for the BE instruction encoder.
// The master drives commands and consumes words; the slave is the encoder.
interface bp_be_instr_encoder_if;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [3:0]  cmd_op_i;
  logic [4:0]  cmd_rd_i;
  logic [4:0]  cmd_rs1_i;
  logic [4:0]  cmd_rs2_i;
  logic [31:0] cmd_imm_i;
  logic        instr_v_o;
  logic [31:0] instr_o;
  logic        instr_ready_i;
  logic        illegal_cmd_o;

  modport master (
    output cmd_v_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i, instr_ready_i,
    input  cmd_ready_o, instr_v_o, instr_o, illegal_cmd_o
  );

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i, instr_ready_i,
    output cmd_ready_o, instr_v_o, instr_o, illegal_cmd_o
  );
endinterface

// File: rtl/bp_be_instr_encoder.sv
// Turns abstract BE commands into RV64 instruction words on a valid/ready stream.
// LI with a large immediate expands into LUI followed by ADDIW.
module bp_be_instr_encoder (
  input logic clk_i,
  input logic reset_i,
  bp_be_instr_encoder_if.slave enc
);

  typedef enum logic [1:0] {E_IDLE, E_FIRST, E_LAST} state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  state_e state, state_n;

  logic signed [31:0] imm;
  logic        [19:0] li_hi;
  logic        [31:0] word0, word1;
  logic               dec_illegal, dec_two;
  logic               accept;

  logic        [31:0] instr_p1;
  logic        [31:0] pending_p1;
  logic               illegal_p1;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm12, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm12, rs1, f3, rd, opc};
  endfunction

  assign imm = enc.cmd_imm_i;
  // Rounding the upper part by bit 11 absorbs the sign of the ADDIW low part.
  assign li_hi = enc.cmd_imm_i[31:12] + {19'b0, enc.cmd_imm_i[11]};

  always_comb begin
    dec_illegal = 1'b0;
    dec_two     = 1'b0;
    word0       = NOP_WORD;
    word1       = NOP_WORD;
    case (enc.cmd_op_i)
      4'd0: word0 = NOP_WORD;
      4'd1: word0 = r_type(7'h00, enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b000, enc.cmd_rd_i);
      4'd2: word0 = r_type(7'h20, enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b000, enc.cmd_rd_i);
      4'd3: word0 = r_type(7'h00, enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b111, enc.cmd_rd_i);
      4'd4: word0 = r_type(7'h00, enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b110, enc.cmd_rd_i);
      4'd5: word0 = r_type(7'h00, enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b100, enc.cmd_rd_i);
      4'd6: begin
        if (in_range(imm, -32'sd2048, 32'sd2047))
          word0 = i_type(imm[11:0], enc.cmd_rs1_i, 3'b000, enc.cmd_rd_i, 7'h13);
        else
          dec_illegal = 1'b1;
      end
      4'd7: begin
        if (in_range(imm, -32'sd2048, 32'sd2047)) begin
          word0 = i_type(imm[11:0], 5'd0, 3'b000, enc.cmd_rd_i, 7'h13);
        end else begin
          word0 = {li_hi, enc.cmd_rd_i, 7'h37};
          if (imm[11:0] != 12'd0) begin
            dec_two = 1'b1;
            word1   = i_type(imm[11:0], enc.cmd_rd_i, 3'b000, enc.cmd_rd_i, 7'h1B);
          end
        end
      end
      4'd8: begin
        if (in_range(imm, -32'sd2048, 32'sd2047))
          word0 = i_type(imm[11:0], enc.cmd_rs1_i, 3'b011, enc.cmd_rd_i, 7'h03);
        else
          dec_illegal = 1'b1;
      end
      4'd9: begin
        if (in_range(imm, -32'sd2048, 32'sd2047))
          word0 = {imm[11:5], enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b011, imm[4:0], 7'h23};
        else
          dec_illegal = 1'b1;
      end
      4'd10: begin
        if (!imm[0] && in_range(imm, -32'sd4096, 32'sd4094))
          word0 = {imm[12], imm[10:5], enc.cmd_rs2_i, enc.cmd_rs1_i, 3'b000,
                   imm[4:1], imm[11], 7'h63};
        else
          dec_illegal = 1'b1;
      end
      4'd11: begin
        if (!imm[0] && in_range(imm, -32'sd1048576, 32'sd1048574))
          word0 = {imm[20], imm[10:1], imm[11], imm[19:12], enc.cmd_rd_i, 7'h6F};
        else
          dec_illegal = 1'b1;
      end
      4'd12: word0 = {12'hF14, 5'd0, 3'b010, enc.cmd_rd_i, 7'h73};
      default: dec_illegal = 1'b1;
    endcase
  end

  assign enc.cmd_ready_o = (state == E_IDLE) || ((state == E_LAST) && enc.instr_ready_i);
  assign accept          = enc.cmd_v_i && enc.cmd_ready_o;

  always_comb begin
    state_n = state;
    case (state)
      E_IDLE: begin
        if (accept)
          state_n = dec_illegal ? E_IDLE : (dec_two ? E_FIRST : E_LAST);
      end
      E_FIRST: begin
        if (enc.instr_ready_i) state_n = E_LAST;
      end
      E_LAST: begin
        if (enc.instr_ready_i) begin
          if (accept)
            state_n = dec_illegal ? E_IDLE : (dec_two ? E_FIRST : E_LAST);
          else
            state_n = E_IDLE;
        end
      end
      default: state_n = E_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= E_IDLE;
    else         state <= state_n;
  end

  // Output stage: held word, pending ADDIW and the illegal pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instr_p1   <= 32'd0;
      pending_p1 <= 32'd0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= accept && dec_illegal;
      if (accept && !dec_illegal) begin
        instr_p1 <= word0;
        if (dec_two) pending_p1 <= word1;
      end else if ((state == E_FIRST) && enc.instr_ready_i) begin
        instr_p1 <= pending_p1;
      end
    end
  end

  assign enc.instr_v_o     = (state != E_IDLE);
  assign enc.instr_o       = instr_p1;
  assign enc.illegal_cmd_o = illegal_p1;

endmodule

// File: tb/tb_bp_be_instr_encoder.sv
// Randomized bench for bp_be_instr_encoder against a queue-based reference model.
module tb_bp_be_instr_encoder;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bp_be_instr_encoder_if bus();

  bp_be_instr_encoder dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .enc    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  bit exp_ill = 1'b0;

  int bvals[15] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 4095,
                    1048574, 1048576, -1048576, -1048578, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: legality and word list per command, from plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                output bit ill, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    longint s, lo_s, hi_l;
    logic [19:0] hi;
    s  = longint'($signed(imm));
    ill = 1'b0; n = 1; w0 = 32'h13; w1 = 32'h0;
    case (op)
      4'd0: w0 = 32'h13;
      4'd1: w0 = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      4'd2: w0 = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      4'd3: w0 = {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
      4'd4: w0 = {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
      4'd5: w0 = {7'h00, rs2, rs1, 3'b100, rd, 7'h33};
      4'd6: if (s >= -2048 && s <= 2047) w0 = {imm[11:0], rs1, 3'b000, rd, 7'h13}; else ill = 1;
      4'd7: begin
        if (s >= -2048 && s <= 2047) begin
          w0 = {imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          lo_s = longint'(imm[11:0]);
          if (lo_s >= 2048) lo_s = lo_s - 4096;
          hi_l = (s - lo_s) >>> 12;
          hi   = hi_l[19:0];
          w0   = {hi, rd, 7'h37};
          if (imm[11:0] != 12'd0) begin
            n  = 2;
            w1 = {imm[11:0], rd, 3'b000, rd, 7'h1B};
          end
        end
      end
      4'd8: if (s >= -2048 && s <= 2047) w0 = {imm[11:0], rs1, 3'b011, rd, 7'h03}; else ill = 1;
      4'd9: if (s >= -2048 && s <= 2047) w0 = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'h23};
            else ill = 1;
      4'd10: if (s % 2 == 0 && s >= -4096 && s <= 4094)
               w0 = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
             else ill = 1;
      4'd11: if (s % 2 == 0 && s >= -1048576 && s <= 1048574)
               w0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
             else ill = 1;
      4'd12: w0 = {12'hF14, 5'd0, 3'b010, rd, 7'h73};
      default: ill = 1;
    endcase
    if (ill) n = 0;
  endfunction

  task automatic check_outputs();
    chk("illegal_pulse", {31'b0, bus.illegal_cmd_o}, {31'b0, exp_ill});
    chk("instr_v", {31'b0, bus.instr_v_o}, {31'b0, q.size() != 0});
    if (q.size() != 0) chk("instr_word", bus.instr_o, q[0]);
  endtask

  // One clock: check last edge's results, drive, then advance the model for the next edge.
  task automatic step(input bit v, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit rdy);
    bit ill, exp_rdy, acc, cons;
    int n;
    logic [31:0] w0, w1;
    @(negedge clk);
    check_outputs();
    bus.cmd_v_i = v; bus.cmd_op_i = op; bus.cmd_rd_i = rd;
    bus.cmd_rs1_i = rs1; bus.cmd_rs2_i = rs2; bus.cmd_imm_i = imm;
    bus.instr_ready_i = rdy;
    #1;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && rdy);
    chk("cmd_ready", {31'b0, bus.cmd_ready_o}, {31'b0, exp_rdy});
    cons = (q.size() != 0) && rdy;
    acc  = v && exp_rdy;
    if (cons) void'(q.pop_front());
    exp_ill = 1'b0;
    if (acc) begin
      model(op, rd, rs1, rs2, imm, ill, n, w0, w1);
      if (ill) exp_ill = 1'b1;
      else begin
        q.push_back(w0);
        if (n == 2) q.push_back(w1);
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1);
  endtask

  task automatic pin(input string name, input logic [3:0] op, input logic [4:0] rd,
                     input logic [31:0] imm, input bit e_ill, input int e_n,
                     input logic [31:0] e_w0, input logic [31:0] e_w1);
    bit ill; int n; logic [31:0] w0, w1;
    model(op, rd, 5'd1, 5'd2, imm, ill, n, w0, w1);
    chk({name, "_ill"}, {31'b0, ill}, {31'b0, e_ill});
    chk({name, "_n"}, n, e_n);
    if (e_n > 0) chk({name, "_w0"}, w0, e_w0);
    if (e_n > 1) chk({name, "_w1"}, w1, e_w1);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = $urandom_range(0, 4095) - 32'd2048;
      1: r = bvals[$urandom_range(0, 14)];
      2: r = $urandom & 32'hFFFF_F000;
      3: r = ($urandom_range(0, 32'h1F_FFFF) - 32'h10_0000) & 32'hFFFF_FFFE;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    bus.cmd_v_i = 0; bus.cmd_op_i = 0; bus.cmd_rd_i = 0; bus.cmd_rs1_i = 0;
    bus.cmd_rs2_i = 0; bus.cmd_imm_i = 0; bus.instr_ready_i = 0;

    pin("m_add", 4'd1, 5'd3, 32'd0, 0, 1, 32'h002081B3, 32'h0);
    pin("m_li_big", 4'd7, 5'd5, 32'h12345678, 0, 2, 32'h123452B7, 32'h6782829B);
    pin("m_li_fff", 4'd7, 5'd5, 32'h00000FFF, 0, 2, 32'h000012B7, 32'hFFF2829B);
    pin("m_li_neg", 4'd7, 5'd6, -32'sd5, 0, 1, 32'hFFB00313, 32'h0);
    pin("m_li_lo0", 4'd7, 5'd7, 32'h00001000, 0, 1, 32'h000013B7, 32'h0);
    pin("m_addi_2048", 4'd6, 5'd1, 32'd2048, 1, 0, 32'h0, 32'h0);
    pin("m_beq_odd", 4'd10, 5'd1, 32'd3, 1, 0, 32'h0, 32'h0);
    pin("m_op14", 4'd14, 5'd1, 32'd0, 1, 0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("reset_v", {31'b0, bus.instr_v_o}, 32'd0);
    chk("reset_instr", bus.instr_o, 32'd0);
    chk("reset_illegal", {31'b0, bus.illegal_cmd_o}, 32'd0);
    chk("reset_ready", {31'b0, bus.cmd_ready_o}, 32'd1);
    reset_i = 1'b0;

    step(1, 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    @(posedge clk); #2;
    chk("add_literal", bus.instr_o, 32'h002081B3);
    idle(2);

    step(1, 4'd7, 5'd5, 5'd0, 5'd0, 32'h12345678, 1);
    @(posedge clk); #2;
    chk("lui_literal", bus.instr_o, 32'h123452B7);
    step(1, 4'd7, 5'd5, 5'd0, 5'd0, 32'h12345678, 0);
    step(1, 4'd7, 5'd5, 5'd0, 5'd0, 32'h12345678, 0);
    step(1, 4'd7, 5'd5, 5'd0, 5'd0, 32'h12345678, 0);
    step(0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1);
    @(posedge clk); #2;
    chk("addiw_literal", bus.instr_o, 32'h6782829B);
    idle(2);

    step(1, 4'd7, 5'd5, 5'd0, 5'd0, 32'h00000FFF, 1);
    step(1, 4'd7, 5'd6, 5'd0, 5'd0, -32'sd5, 1);
    step(1, 4'd7, 5'd7, 5'd0, 5'd0, 32'h00001000, 1);
    step(1, 4'd6, 5'd1, 5'd2, 5'd0, 32'd2048, 1);
    step(1, 4'd10, 5'd1, 5'd2, 5'd3, 32'd3, 1);
    step(1, 4'd14, 5'd1, 5'd2, 5'd3, 32'd0, 1);
    idle(3);

    step(1, 4'd7, 5'd5, 5'd0, 5'd0, 32'h12345678, 1);
    @(posedge clk); #2;
    chk("pre_reset_v", {31'b0, bus.instr_v_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("midli_reset_v", {31'b0, bus.instr_v_o}, 32'd0);
    chk("midli_reset_ready", {31'b0, bus.cmd_ready_o}, 32'd1);
    chk("midli_reset_instr", bus.instr_o, 32'd0);
    q.delete();
    exp_ill = 1'b0;
    bus.cmd_v_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    idle(3);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 5'($urandom),
           5'($urandom), 5'($urandom), rand_imm(), $urandom_range(0, 3) != 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
